// File: rtl/apb_master_arb_if.sv
// APB bus bundle between apb_master_arb and its slaves.
// Widths follow the global ADDR_WIDTH / DATA_WIDTH macros (32 bits when not supplied).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface apb_master_arb_if;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [`ADDR_WIDTH-1:0] paddr;
  logic [`DATA_WIDTH-1:0] pwdata;
  logic [`DATA_WIDTH-1:0] prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin APB master shared by NUM_REQ requesters (IDLE -> SETUP -> ACCESS).
// Define APB3_EN to honour pready/pslverr; otherwise ACCESS is one cycle and err stays 0.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_master_arb #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                           pclk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*`ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [`DATA_WIDTH-1:0]         rdata,
  output logic                           err,
  apb_master_arb_if.master               apb
);

  localparam int unsigned AW   = `ADDR_WIDTH;
  localparam int unsigned DW   = `DATA_WIDTH;
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [AW-1:0]       paddr_q, paddr_d;
  logic [DW-1:0]       pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [IdxW-1:0]     last_q, last_d;

  logic                ready;
  logic                slverr;
  logic [NUM_REQ-1:0]  masked;
  logic                win_found;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     cand;

`ifdef APB3_EN
  assign ready  = apb.pready;
  assign slverr = apb.pslverr;
`else
  logic unused_apb3;
  assign unused_apb3 = apb.pready ^ apb.pslverr;
  assign ready       = 1'b1;
  assign slverr      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    last_d    = last_q;

    // The requester being acknowledged this cycle must not win again.
    masked    = req & ~ack_q;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_REQ);
      if (!win_found && masked[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d  = StSetup;
          psel_d   = 1'b1;
          pwrite_d = req_write[win_idx];
          paddr_d  = req_addr[32'(win_idx)*AW +: AW];
          pwdata_d = req_wdata[32'(win_idx)*DW +: DW];
          last_d   = win_idx;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (ready) begin
          state_d        = StIdle;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          ack_d[last_q]  = 1'b1;
          err_d          = slverr;
          if (!pwrite_q) begin
            rdata_d = apb.prdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      last_q    <= IdxW'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized bench for apb_master_arb: transaction-level reference model of
// round-robin grants, phase timing, read data / error return and mid-transfer reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_apb_master_arb;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;
`ifdef APB3_EN
  localparam bit Apb3 = 1'b1;
`else
  localparam bit Apb3 = 1'b0;
`endif

  localparam int PhIdle   = 0;
  localparam int PhSetup  = 1;
  localparam int PhAccess = 2;

  logic              pclk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rdata;
  logic              err;

  apb_master_arb_if apb ();

  apb_master_arb #(.NUM_REQ(N)) dut (
    .pclk      (pclk),
    .rstn      (rstn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .apb       (apb)
  );

  always #5 pclk = ~pclk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference-model state
  int            ph;
  int unsigned   last_m;
  int unsigned   win;
  logic          exp_write;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  logic [N-1:0]  prev_ack;
  bit            heavy;
  int unsigned   n_grants = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First requesting index strictly after 'last', wrapping; N means nobody.
  function automatic int unsigned rr_pick(input logic [N-1:0] m, input int unsigned last);
    for (int unsigned k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return N;
  endfunction

  task automatic check_bus_held(input string tag);
    check_eq({tag, "_psel"}, apb.psel, 1);
    check_eq({tag, "_penable"}, apb.penable, (ph == PhSetup) ? 0 : 1);
    check_eq({tag, "_pwrite"}, apb.pwrite, exp_write);
    check_eq({tag, "_paddr"}, apb.paddr, exp_addr);
    check_eq({tag, "_pwdata"}, apb.pwdata, exp_wdata);
    check_eq({tag, "_ack"}, ack, 0);
  endtask

  task automatic monitor();
    logic [N-1:0] masked;
    logic [N-1:0] onehot;
    int unsigned  w;
    logic         eff_ready;
    masked = req & ~prev_ack;
    case (ph)
      PhIdle: begin
        w = rr_pick(masked, last_m);
        if (w < N) begin
          win       = w;
          last_m    = w;
          exp_write = req_write[w];
          exp_addr  = req_addr[w*AW +: AW];
          exp_wdata = req_wdata[w*DW +: DW];
          ph        = PhSetup;
          n_grants++;
          check_bus_held("setup");
        end else begin
          check_eq("idle_psel", apb.psel, 0);
          check_eq("idle_penable", apb.penable, 0);
          check_eq("idle_ack", ack, 0);
        end
      end
      PhSetup: begin
        ph = PhAccess;
        check_bus_held("access_entry");
      end
      default: begin
        eff_ready = Apb3 ? apb.pready : 1'b1;
        if (eff_ready) begin
          onehot      = '0;
          onehot[win] = 1'b1;
          check_eq("done_ack", ack, onehot);
          check_eq("done_psel", apb.psel, 0);
          check_eq("done_penable", apb.penable, 0);
          if (!exp_write) exp_rdata = apb.prdata;
          exp_err = Apb3 ? apb.pslverr : 1'b0;
          ph = PhIdle;
        end else begin
          check_bus_held("wait");
        end
      end
    endcase
    check_eq("rdata", rdata, exp_rdata);
    check_eq("err", err, exp_err);
    prev_ack = ack;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (ack[i] || !req[i]) begin
        req[i]               = heavy || ($urandom_range(0, 2) == 0);
        req_write[i]         = 1'($urandom_range(0, 1));
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
      end
    end
    apb.pready  = ($urandom_range(0, 2) != 0);
    apb.pslverr = 1'($urandom_range(0, 1));
    apb.prdata  = DW'($urandom);
  endtask

  task automatic model_reset();
    ph        = PhIdle;
    last_m    = N - 1;
    prev_ack  = '0;
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_psel"}, apb.psel, 0);
    check_eq({tag, "_penable"}, apb.penable, 0);
    check_eq({tag, "_pwrite"}, apb.pwrite, 0);
    check_eq({tag, "_paddr"}, apb.paddr, 0);
    check_eq({tag, "_pwdata"}, apb.pwdata, 0);
    check_eq({tag, "_ack"}, ack, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  initial begin
    bit          want_reset;
    int unsigned resets_done;
    rstn        = 1'b0;
    req         = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = '0;
    heavy       = 1'b0;
    want_reset  = 1'b0;
    resets_done = 0;
    model_reset();

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_all_zero("reset");

    rstn = 1'b1;
    drive();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge pclk);
      monitor();
      if (cyc % 250 == 0) heavy = ~heavy;
      if (cyc == 1500 || cyc == 3000) want_reset = 1'b1;
      if (want_reset && ph == PhAccess) begin
        // Drop the in-flight transfer: outputs clear at once and no ack follows.
        want_reset = 1'b0;
        resets_done++;
        #2 rstn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge pclk);
        check_all_zero("reset_hold");
        req = '1;
        for (int i = 0; i < N; i++) begin
          req_write[i]          = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]  = AW'($urandom);
          req_wdata[i*DW +: DW] = DW'($urandom);
        end
        model_reset();
        rstn = 1'b1;
      end else begin
        drive();
      end
    end

    check_eq("resets_injected", resets_done, 2);
    check_eq("enough_grants", (n_grants > 200) ? 1 : 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
